updown_sweep_ctrl: RTL and testbench

UPDOWN_SWEEP_CTRL -- requirements
Module: updown_sweep_ctrl

---
 rtl/updown_sweep_pkg.sv | 18 +
 rtl/up_down_counter.sv | 25 ++
 rtl/updown_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_sweep_pkg.sv
// Shared types and constants for the up/down sweep controller.
// Holds the controller state encoding and the dwell-time limits.
package updown_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNT_UP   = 3'd1,
        DWELL_TOP  = 3'd2,
        COUNT_DOWN = 3'd3,
        DWELL_BOT  = 3'd4
    } sweep_state_e;

    localparam int DWELL_DEFAULT = 2;
    localparam int DWELL_MIN     = 1;
    localparam int DWELL_MAX     = 255;
    localparam int DWELL_CNT_W   = 8;

endpackage

// File: rtl/up_down_counter.sv
// Plain up/down counter with enable; wraps naturally, so the controller
// is responsible for never driving it past its turn points.
module up_down_counter #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    output logic [BITS-1:0] Q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Q <= '0;
        end else if (enable) begin
            if (up) begin
                Q <= Q + BITS'(1);
            end else begin
                Q <= Q - BITS'(1);
            end
        end
    end

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Sweeps the counter from its current value up to top, dwells, down to bottom,
// dwells, then finishes. Define SWEEP_CONTINUOUS_EN to repeat sweeps until stop.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int BITS  = 4,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stop,
    input  logic [BITS-1:0] top,
    input  logic [BITS-1:0] bottom,
    output logic [BITS-1:0] Q,
    output logic            busy,
    output logic            dir_up,
    output logic            done,
    output logic            err,
    output sweep_state_e    state_dbg
);

    localparam logic [DWELL_CNT_W-1:0] DWELL_LAST = DWELL_CNT_W'(DWELL - 1);

    sweep_state_e           state;
    logic [BITS-1:0]        top_l;
    logic [BITS-1:0]        bot_l;
    logic [DWELL_CNT_W-1:0] dcnt;
    logic                   up;
    logic                   enable;
    logic                   at_top;
    logic                   at_bot;

    // Protocol: start is a one-cycle request honoured only in IDLE (and only
    // when stop is low); stop is a level abort honoured in every busy state.
    // Comparing with >= / <= lets a count that starts beyond a turn point
    // fall straight through instead of wrapping.
    assign at_top = (Q >= top_l);
    assign at_bot = (Q <= bot_l);

    always_comb begin
        enable = 1'b0;
        if (!stop) begin
            if (state == COUNT_UP && !at_top) begin
                enable = 1'b1;
            end else if (state == COUNT_DOWN && !at_bot) begin
                enable = 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dir_up    = up;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            top_l <= '0;
            bot_l <= '0;
            dcnt  <= '0;
            up    <= 1'b1;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (stop && state != IDLE) begin
                state <= IDLE;
                dcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !stop) begin
                            if (bottom < top) begin
                                top_l <= top;
                                bot_l <= bottom;
                                up    <= 1'b1;
                                state <= COUNT_UP;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    COUNT_UP: begin
                        if (at_top) begin
                            state <= DWELL_TOP;
                            dcnt  <= '0;
                        end
                    end
                    DWELL_TOP: begin
                        if (dcnt == DWELL_LAST) begin
                            state <= COUNT_DOWN;
                            up    <= 1'b0;
                            dcnt  <= '0;
                        end else begin
                            dcnt <= dcnt + DWELL_CNT_W'(1);
                        end
                    end
                    COUNT_DOWN: begin
                        if (at_bot) begin
                            state <= DWELL_BOT;
                            dcnt  <= '0;
                        end
                    end
                    DWELL_BOT: begin
                        if (dcnt == DWELL_LAST) begin
                            done <= 1'b1;
                            dcnt <= '0;
`ifdef SWEEP_CONTINUOUS_EN
                            state <= COUNT_UP;
                            up    <= 1'b1;
`else
                            state <= IDLE;
`endif
                        end else begin
                            dcnt <= dcnt + DWELL_CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    up_down_counter #(
        .BITS(BITS)
    ) u_counter (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .up     (up),
        .Q      (Q)
    );

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl (BITS=4, DWELL=2, 10 ns clock).
// Outputs are sampled on the falling edge; inputs change just after the rising edge.
module tb_updown_sweep_ctrl;
    import updown_sweep_pkg::*;

    localparam int BITS  = 4;
    localparam int DWELL = 2;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            stop;
    logic [BITS-1:0] top;
    logic [BITS-1:0] bottom;
    logic [BITS-1:0] Q;
    logic            busy;
    logic            dir_up;
    logic            done;
    logic            err;
    sweep_state_e    state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    updown_sweep_ctrl #(
        .BITS (BITS),
        .DWELL(DWELL)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .top      (top),
        .bottom   (bottom),
        .Q        (Q),
        .busy     (busy),
        .dir_up   (dir_up),
        .done     (done),
        .err      (err),
        .state_dbg(state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic do_start(input logic [BITS-1:0] t, input logic [BITS-1:0] b);
        top    = t;
        bottom = b;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    // scoreboard: expected {busy, dir_up, done, err, Q} per cycle
    task automatic push_exp(input logic b, input logic d, input logic dn, input logic e,
                            input logic [BITS-1:0] q);
        exp_q.push_back({b, d, dn, e, q});
    endtask

    task automatic run_trace(input string tag);
        int k;
        logic [7:0] exp_v;
        k = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp_v = exp_q.pop_front();
            check_eq($sformatf("%s_k%0d", tag, k), 32'({busy, dir_up, done, err, Q}), 32'(exp_v));
            k++;
        end
    endtask

    initial begin
        logic [BITS-1:0] q_hold;
        logic [BITS-1:0] maxq;
        logic [BITS-1:0] minq;
        logic [BITS-1:0] prevq;
        int found;
        int done_k;
        int wraps;
        int dones;

        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        top     = '0;
        bottom  = '0;

        // reset state
        #12;
        check_eq("rst_q", 32'(Q), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dir", 32'(dir_up), 32'd1);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_state", 32'(state_dbg), 32'(IDLE));

        // basic sweep 0 -> 9 -> 3
        for (int q = 0; q <= 9; q++) push_exp(1, 1, 0, 0, BITS'(q));
        push_exp(1, 1, 0, 0, 4'd9);
        push_exp(1, 1, 0, 0, 4'd9);
        for (int q = 9; q >= 3; q--) push_exp(1, 0, 0, 0, BITS'(q));
        push_exp(1, 0, 0, 0, 4'd3);
        push_exp(1, 0, 0, 0, 4'd3);
`ifdef SWEEP_CONTINUOUS_EN
        push_exp(1, 1, 1, 0, 4'd3);
        push_exp(1, 1, 0, 0, 4'd4);
        q_hold = 4'd4;
`else
        push_exp(0, 0, 1, 0, 4'd3);
        push_exp(0, 0, 0, 0, 4'd3);
        q_hold = 4'd3;
`endif
        @(negedge clk);
        do_start(4'd9, 4'd3);
        run_trace("sweep");
        pulse_stop();

        // rejected start: bottom == top
        @(negedge clk);
        do_start(4'd9, 4'd9);
        @(negedge clk);
        check_eq("rej_err", 32'(err), 32'd1);
        check_eq("rej_busy", 32'(busy), 32'd0);
        check_eq("rej_q", 32'(Q), 32'(q_hold));
        @(negedge clk);
        check_eq("rej_err_clr", 32'(err), 32'd0);
        check_eq("rej_busy2", 32'(busy), 32'd0);

        // stop and start in the same idle cycle: stop wins, no err
        stop = 1'b1;
        do_start(4'd12, 4'd0);
        stop = 1'b0;
        @(negedge clk);
        check_eq("ss_busy", 32'(busy), 32'd0);
        check_eq("ss_err", 32'(err), 32'd0);

        // mid-sweep stop at Q=6 counting up
        do_start(4'd12, 4'd0);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            @(negedge clk);
            if (Q == 4'd6) found = 1;
        end
        check_eq("stop_reach6", 32'(found), 32'd1);
        pulse_stop();
        @(negedge clk);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_q", 32'(Q), 32'd6);
        check_eq("stop_done", 32'(done), 32'd0);
        @(negedge clk);
        check_eq("stop_q_hold", 32'(Q), 32'd6);
        check_eq("stop_done2", 32'(done), 32'd0);

        // restart 6 -> 15, then async reset at Q=12 while counting down
        do_start(4'd15, 4'd0);
        found = 0;
        maxq = '0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(negedge clk);
            if (Q > maxq) maxq = Q;
            if (!dir_up && Q == 4'd12) found = 1;
        end
        check_eq("down_reach12", 32'(found), 32'd1);
        check_eq("restart_max", 32'(maxq), 32'd15);
        #1 reset_n = 1'b0;
        #1;
        check_eq("arst_q", 32'(Q), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_dir", 32'(dir_up), 32'd1);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_eq("arst_idle", 32'(state_dbg), 32'(IDLE));
        check_eq("arst_q2", 32'(Q), 32'd0);

        // full range sweep: no wrap at 15 or 0
        do_start(4'd15, 4'd0);
        done_k = 0;
        wraps = 0;
        maxq = '0;
        minq = 4'd15;
        prevq = Q;
        for (int k = 1; k <= 60 && done_k == 0; k++) begin
            @(negedge clk);
            if (Q > maxq) maxq = Q;
            if (maxq == 4'd15 && Q < minq) minq = Q;
            if ((Q > prevq && Q - prevq > 1) || (prevq > Q && prevq - Q > 1)) wraps++;
            prevq = Q;
            if (done) done_k = k;
        end
        check_eq("full_done_cycle", 32'(done_k), 32'd37);
        check_eq("full_max", 32'(maxq), 32'd15);
        check_eq("full_min", 32'(minq), 32'd0);
        check_eq("full_wraps", 32'(wraps), 32'd0);
        @(negedge clk);
        check_eq("full_done_clr", 32'(done), 32'd0);
        pulse_stop();

`ifdef SWEEP_CONTINUOUS_EN
        // continuous: three sweeps, then stop during DWELL_TOP
        @(negedge clk);
        do_start(4'd9, 4'd3);
        dones = 0;
        for (int i = 0; i < 300 && dones < 3; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check_eq("cont_dones", 32'(dones), 32'd3);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (state_dbg == DWELL_TOP) found = 1;
        end
        check_eq("cont_dwell_top", 32'(found), 32'd1);
        pulse_stop();
        @(negedge clk);
        check_eq("cont_stop_busy", 32'(busy), 32'd0);
        check_eq("cont_stop_q", 32'(Q), 32'd9);
`else
        dones = 0;
`endif

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
